shift_op_sequencer: RTL and testbench

Multi-cycle shifter-operand unit for the ARM-subset CPU. It decodes the operand-2 field of an instruction (immediate shift, register shift, rotated 8-bit immediate) and produces the shifted value and shifter carry-out. The shift is performed iteratively, STEP bit positions per cycle. Valid/ready handshakes on input and output let the control unit stall on it in place of a single-cycle barrel shifter.

---
 rtl/shift_op_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_shift_op_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_op_sequencer.sv
// Iterative operand-2 shifter for the ARM-subset CPU: decodes the shifter field,
// then shifts STEP bit positions per cycle behind valid/ready handshakes.
module shift_op_sequencer #(
    parameter int STEP  = 4,
    parameter int CNT_W = 6
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] IR,
    input  logic [31:0] Rm,
    input  logic [31:0] Rs,
    input  logic        SR29_IN,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] Out,
    output logic        SR29_OUT,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [1:0] LSL = 2'b00;
    localparam logic [1:0] LSR = 2'b01;
    localparam logic [1:0] ASR = 2'b10;
    localparam logic [1:0] ROR = 2'b11;

    state_t state, next_state;

    logic [31:0]      value;
    logic             carry;
    logic [CNT_W-1:0] count;
    logic [1:0]       shift_type;

    logic [31:0]      dec_value;
    logic             dec_carry;
    logic [CNT_W-1:0] dec_count;
    logic [1:0]       dec_type;
    logic [4:0]       imm_amt;
    logic [7:0]       reg_amt;

    logic [CNT_W-1:0] step_amt;
    logic [32:0]      lsl_ext;
    logic [32:0]      lsr_ext;
    logic [32:0]      asr_ext;
    logic [31:0]      ror_val;
    logic [31:0]      next_value;
    logic             next_carry;

    logic unused_bits;
    assign unused_bits = ^{IR[31:28], IR[24:12], Rs[31:8]};

    // Operand decode: zero-count cases resolve here and skip the SHIFT state.
    always_comb begin
        dec_value = Rm;
        dec_carry = SR29_IN;
        dec_count = '0;
        dec_type  = IR[6:5];
        imm_amt   = IR[11:7];
        reg_amt   = Rs[7:0];
        if (IR[27:25] == 3'b000 && !IR[4]) begin
            case (IR[6:5])
                LSL: dec_count = CNT_W'(imm_amt);
                LSR, ASR: dec_count = (imm_amt == 5'd0) ? CNT_W'(32) : CNT_W'(imm_amt);
                default: begin
                    if (imm_amt == 5'd0) begin
                        dec_value = {SR29_IN, Rm[31:1]};
                        dec_carry = Rm[0];
                    end else begin
                        dec_count = CNT_W'(imm_amt);
                    end
                end
            endcase
        end else if (IR[27:25] == 3'b000) begin
            if (reg_amt != 8'd0) begin
                case (IR[6:5])
                    LSL, LSR: begin
                        if (reg_amt > 8'd32) begin
                            dec_value = '0;
                            dec_carry = 1'b0;
                        end else begin
                            dec_count = CNT_W'(reg_amt);
                        end
                    end
                    ASR: dec_count = (reg_amt >= 8'd32) ? CNT_W'(32) : CNT_W'(reg_amt);
                    default: begin
                        if (reg_amt[4:0] == 5'd0) begin
                            dec_carry = Rm[31];
                        end else begin
                            dec_count = CNT_W'(reg_amt[4:0]);
                        end
                    end
                endcase
            end
        end else if (IR[27:25] == 3'b001) begin
            dec_value = {24'h0, IR[7:0]};
            dec_type  = ROR;
            dec_count = CNT_W'({IR[11:8], 1'b0});
        end
    end

    // One iteration: the extra bit of each extended vector is the last bit shifted out.
    always_comb begin
        step_amt = (count < CNT_W'(STEP)) ? count : CNT_W'(STEP);
        lsl_ext  = {1'b0, value} << step_amt;
        lsr_ext  = {value, 1'b0} >> step_amt;
        asr_ext  = $signed({value, 1'b0}) >>> step_amt;
        ror_val  = (value >> step_amt) | (value << (CNT_W'(32) - step_amt));
        case (shift_type)
            LSL: begin
                next_value = lsl_ext[31:0];
                next_carry = lsl_ext[32];
            end
            LSR: begin
                next_value = lsr_ext[32:1];
                next_carry = lsr_ext[0];
            end
            ASR: begin
                next_value = asr_ext[32:1];
                next_carry = asr_ext[0];
            end
            default: begin
                next_value = ror_val;
                next_carry = ror_val[31];
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    next_state = (dec_count == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (count == step_amt) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            value      <= '0;
            carry      <= 1'b0;
            count      <= '0;
            shift_type <= LSL;
        end else if (state == IDLE && in_valid) begin
            value      <= dec_value;
            carry      <= dec_carry;
            count      <= dec_count;
            shift_type <= dec_type;
        end else if (state == SHIFT) begin
            value <= next_value;
            carry <= next_carry;
            count <= count - step_amt;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign Out       = value;
    assign SR29_OUT  = carry;

endmodule

// File: tb/tb_shift_op_sequencer.sv
// Self-checking bench for shift_op_sequencer: directed cases pinned to literals,
// then randomized requests checked every cycle against a whole-shift arithmetic model.
module tb_shift_op_sequencer;

    localparam int STEP = 4;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] IR;
    logic [31:0] Rm;
    logic [31:0] Rs;
    logic        SR29_IN;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Out;
    logic        SR29_OUT;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    shift_op_sequencer #(.STEP(STEP), .CNT_W(6)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .IR(IR),
        .Rm(Rm),
        .Rs(Rs),
        .SR29_IN(SR29_IN),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Out(Out),
        .SR29_OUT(SR29_OUT),
        .busy(busy)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        n_checks++;
        if (actual === required) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, required);
        end
    endtask

    task automatic reportTimeout(input string name);
        n_checks++;
        $display("[TB] FAIL %s: got no response, expected one within the cycle bound", name);
    endtask

    function automatic int latencyOf(input int n);
        return (n + STEP - 1) / STEP + 1;
    endfunction

    // Whole-shift reference: applies the full amount in one arithmetic step.
    function automatic void model(input logic [31:0] ir, input logic [31:0] rm, input logic [31:0] rs,
                                  input logic cin, output logic [31:0] o, output logic c, output int n);
        logic [1:0]         typ;
        int                 k;
        int                 a;
        logic [63:0]        w;
        logic signed [63:0] sw;
        o   = rm;
        c   = cin;
        n   = 0;
        k   = 0;
        typ = ir[6:5];
        if (ir[27:25] == 3'b000 && ir[4] == 1'b0) begin
            a = int'(ir[11:7]);
            if (a == 0 && typ == 2'b11) begin
                o = {cin, rm[31:1]};
                c = rm[0];
            end else if (a == 0 && typ != 2'b00) begin
                k = 32;
            end else begin
                k = a;
            end
        end else if (ir[27:25] == 3'b000) begin
            a = int'(rs[7:0]);
            if (a != 0) begin
                if (typ == 2'b00 || typ == 2'b01) begin
                    if (a > 32) begin
                        o = 32'h0;
                        c = 1'b0;
                    end else begin
                        k = a;
                    end
                end else if (typ == 2'b10) begin
                    k = (a >= 32) ? 32 : a;
                end else if (a % 32 == 0) begin
                    c = rm[31];
                end else begin
                    k = a % 32;
                end
            end
        end else if (ir[27:25] == 3'b001) begin
            o   = {24'h0, ir[7:0]};
            typ = 2'b11;
            k   = 2 * int'(ir[11:8]);
        end
        if (k > 0) begin
            n = k;
            case (typ)
                2'b00: begin
                    w = {32'h0, o} << k;
                    c = w[32];
                    o = w[31:0];
                end
                2'b01: begin
                    w = {o, 32'h0} >> k;
                    c = w[31];
                    o = w[63:32];
                end
                2'b10: begin
                    sw = $signed({o, 32'h0}) >>> k;
                    c  = sw[31];
                    o  = sw[63:32];
                end
                default: begin
                    o = (o >> k) | (o << (32 - k));
                    c = o[31];
                end
            endcase
        end
    endfunction

    // Cycle-by-cycle compare against the model for each accepted request.
    bit          pending    = 1'b0;
    bit          seen_valid = 1'b0;
    bit          check_idle = 1'b0;
    int          lat        = 0;
    logic [31:0] exp_out;
    logic        exp_c;
    int          exp_n;

    always @(negedge Clk) begin
        if (Reset) begin
            pending    = 1'b0;
            check_idle = 1'b0;
        end else begin
            if (check_idle) begin
                checkOutput("idle_after_consume", {30'h0, in_ready, out_valid}, 32'h2);
                check_idle = 1'b0;
            end
            if (pending) begin
                lat++;
                if (out_valid) begin
                    if (!seen_valid) begin
                        checkOutput("latency", lat, latencyOf(exp_n));
                        seen_valid = 1'b1;
                    end
                    checkOutput("Out", Out, exp_out);
                    checkOutput("SR29_OUT", {31'h0, SR29_OUT}, {31'h0, exp_c});
                    checkOutput("done_ready_busy", {30'h0, in_ready, busy}, 32'h1);
                    if (out_ready) begin
                        pending    = 1'b0;
                        check_idle = 1'b1;
                    end
                end else begin
                    checkOutput("shift_ready_busy", {30'h0, in_ready, busy}, 32'h1);
                    if (lat >= latencyOf(exp_n)) begin
                        checkOutput("valid_on_time", {31'h0, out_valid}, 32'h1);
                        pending = 1'b0;
                    end
                end
            end else if (in_valid && in_ready) begin
                model(IR, Rm, Rs, SR29_IN, exp_out, exp_c, exp_n);
                pending    = 1'b1;
                seen_valid = 1'b0;
                lat        = 0;
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [31:0] ir, input logic [31:0] rm, input logic [31:0] rs,
                                 input logic cin, input int hold,
                                 output logic [31:0] got_out, output logic got_c, output int got_lat);
        int guard;
        guard   = 0;
        got_out = 32'h0;
        got_c   = 1'b0;
        got_lat = 0;
        while (!in_ready && guard < 200) begin
            tick();
            guard++;
        end
        if (!in_ready) begin
            reportTimeout("in_ready_wait");
        end else begin
            IR        = ir;
            Rm        = rm;
            Rs        = rs;
            SR29_IN   = cin;
            in_valid  = 1'b1;
            out_ready = 1'b0;
            tick();
            in_valid = 1'b0;
            IR       = $urandom;
            Rm       = $urandom;
            Rs       = $urandom;
            SR29_IN  = 1'($urandom_range(0, 1));
            got_lat  = 1;
            while (!out_valid && got_lat < 100) begin
                tick();
                got_lat++;
            end
            if (!out_valid) begin
                reportTimeout("out_valid_wait");
            end
            got_out = Out;
            got_c   = SR29_OUT;
            for (int i = 0; i < hold; i++) begin
                tick();
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    task automatic runDirected(input string name, input logic [31:0] ir, input logic [31:0] rm,
                               input logic [31:0] rs, input logic cin, input int hold,
                               input logic [31:0] want_out, input logic want_c, input int want_lat);
        logic [31:0] mo;
        logic        mc;
        int          mn;
        logic [31:0] go;
        logic        gc;
        int          gl;
        model(ir, rm, rs, cin, mo, mc, mn);
        checkOutput({name, "_model_out"}, mo, want_out);
        checkOutput({name, "_model_c"}, {31'h0, mc}, {31'h0, want_c});
        checkOutput({name, "_model_lat"}, latencyOf(mn), want_lat);
        applyStimulus(ir, rm, rs, cin, hold, go, gc, gl);
        checkOutput({name, "_out"}, go, want_out);
        checkOutput({name, "_c"}, {31'h0, gc}, {31'h0, want_c});
        checkOutput({name, "_lat"}, gl, want_lat);
    endtask

    initial begin
        logic [31:0] ir;
        logic [31:0] rs;
        logic [31:0] ro;
        logic        rc;
        int          rl;
        int          sel;

        Reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        IR        = 32'h0;
        Rm        = 32'h0;
        Rs        = 32'h0;
        SR29_IN   = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
        checkOutput("reset_flags", {29'h0, in_ready, out_valid, busy}, 32'h4);
        checkOutput("reset_out", Out, 32'h0);
        checkOutput("reset_c", {31'h0, SR29_OUT}, 32'h0);

        runDirected("imm_lsl4", 32'h0000_0200, 32'h8000_000F, 32'h0, 1'b0, 0, 32'h0000_00F0, 1'b0, 2);
        runDirected("imm_rrx", 32'h0000_0060, 32'h0000_0001, 32'h0, 1'b1, 0, 32'h8000_0000, 1'b1, 1);
        runDirected("reg_lsr32", 32'h0000_0030, 32'h8000_0000, 32'h20, 1'b0, 0, 32'h0, 1'b1, 9);
        runDirected("reg_lsr33", 32'h0000_0030, 32'h8000_0000, 32'h21, 1'b1, 0, 32'h0, 1'b0, 1);
        runDirected("reg_lsr256", 32'h0000_0030, 32'h8000_0000, 32'h100, 1'b1, 0, 32'h8000_0000, 1'b1, 1);
        runDirected("rot_imm", 32'h0200_01FF, 32'h1234_5678, 32'h0, 1'b0, 0, 32'hC000_003F, 1'b1, 2);
        runDirected("imm_asr31_hold", 32'h0000_0FC0, 32'h8000_0000, 32'h0, 1'b1, 3, 32'hFFFF_FFFF, 1'b0, 9);

        // Abort a long register LSR in its third SHIFT cycle.
        IR       = 32'h0000_0030;
        Rm       = 32'h8000_0000;
        Rs       = 32'h20;
        SR29_IN  = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checkOutput("abort_flags", {29'h0, in_ready, out_valid, busy}, 32'h4);
        checkOutput("abort_out", Out, 32'h0);
        checkOutput("abort_c", {31'h0, SR29_OUT}, 32'h0);
        runDirected("post_abort", 32'h0000_0200, 32'h8000_000F, 32'h0, 1'b0, 0, 32'h0000_00F0, 1'b0, 2);

        for (int t = 0; t < 80; t++) begin
            ir  = $urandom;
            rs  = $urandom;
            sel = int'($urandom_range(0, 9));
            if (sel < 4) begin
                ir[27:25] = 3'b000;
                ir[4]     = 1'b0;
                if ($urandom_range(0, 3) == 0) ir[11:7] = 5'd0;
            end else if (sel < 7) begin
                ir[27:25] = 3'b000;
                ir[4]     = 1'b1;
                case ($urandom_range(0, 3))
                    0: rs = rs & 32'hFFFF_FF00;
                    1: rs = (rs & 32'hFFFF_FF00) | 32'h20;
                    2: rs = (rs & 32'hFFFF_FF00) | 32'($urandom_range(0, 40));
                    default: rs = rs;
                endcase
            end else if (sel < 9) begin
                ir[27:25] = 3'b001;
            end else begin
                ir[27:25] = 3'($urandom_range(2, 7));
            end
            applyStimulus(ir, $urandom, rs, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), ro, rc, rl);
        end
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
